// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Drives a shared MAC datapath (result = f1*f2 + a1) to compute an
//   N-element dot product. Operand pairs come from a single synchronous
//   read port. The running sum is fed back through mac_a1. The final sum
//   is reported on acc_out together with a one-cycle done pulse.
//
// Ports
//   clock, resetn             rising-edge clock, async active-low reset
//   start, abort              command strobe (IDLE only) / cancel
//   len, a_base, b_base       command: element count and vector bases
//   busy, done, acc_out       status and last completed dot product
//   mem_rd_en/addr/data       operand memory port (data one cycle later)
//   mac_f1/f2/a1, mac_result  MAC operands and result
module mac_dot_sequencer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int LEN_W   = 10,
   parameter int MAC_LAT = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] acc_out,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [DATA_W-1:0] mac_f1,
   output logic [DATA_W-1:0] mac_f2,
   output logic [DATA_W-1:0] mac_a1,
   input  logic [DATA_W-1:0] mac_result
);

   localparam int WAIT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_ISSUE, S_WB, S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_idx;
   logic [ADDR_W-1:0]   r_a_base;
   logic [ADDR_W-1:0]   r_b_base;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_op_a;
   logic [WAIT_W-1:0]   r_wait;
   logic                r_busy;
   logic                r_done;
   logic [DATA_W-1:0]   r_acc_out;
   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic [DATA_W-1:0]   r_f1;
   logic [DATA_W-1:0]   r_f2;
   logic [DATA_W-1:0]   r_a1;
   logic                w_last;
   logic                w_wait_end;
   logic                w_abort;
   logic [LEN_W-1:0]    w_idx_inc;

   assign w_last     = (r_idx == (r_len - LEN_W'(1)));
   assign w_wait_end = (r_wait == WAIT_W'(MAC_LAT - 1));
   assign w_abort    = abort && (r_state != S_IDLE);
   assign w_idx_inc  = r_idx + LEN_W'(1);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (len != '0) ? S_RD_A : S_DONE;
         S_RD_A:  w_next = S_RD_B;
         S_RD_B:  w_next = S_CAP_B;
         S_CAP_B: w_next = S_ISSUE;
         S_ISSUE: if (w_wait_end) w_next = S_WB;
         S_WB:    w_next = w_last ? S_DONE : S_RD_A;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_IDLE;
   end

   // Outputs are registered: each one is loaded on the edge that enters the
   // state it belongs to, so done/acc_out are set on the edge leaving WB.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_len     <= '0;
         r_idx     <= '0;
         r_a_base  <= '0;
         r_b_base  <= '0;
         r_acc     <= '0;
         r_op_a    <= '0;
         r_wait    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_acc_out <= '0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_f1      <= '0;
         r_f2      <= '0;
         r_a1      <= '0;
      end else begin
         r_done  <= 1'b0;
         r_busy  <= (w_next != S_IDLE);
         r_rd_en <= (w_next == S_RD_A) || (w_next == S_RD_B);
         if (!w_abort) begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_acc    <= '0;
                     r_idx    <= '0;
                     r_len    <= len;
                     r_a_base <= a_base;
                     r_b_base <= b_base;
                     if (len != '0) begin
                        r_rd_addr <= a_base;
                     end else begin
                        r_done    <= 1'b1;
                        r_acc_out <= '0;
                     end
                  end
               end
               S_RD_A:  r_rd_addr <= r_b_base + ADDR_W'(r_idx);
               S_RD_B:  r_op_a <= mem_rd_data;
               S_CAP_B: begin
                  r_f1   <= r_op_a;
                  r_f2   <= mem_rd_data;
                  r_a1   <= r_acc;
                  r_wait <= '0;
               end
               S_ISSUE: if (!w_wait_end) r_wait <= r_wait + WAIT_W'(1);
               S_WB: begin
                  r_acc <= mac_result;
                  if (w_last) begin
                     r_done    <= 1'b1;
                     r_acc_out <= mac_result;
                  end else begin
                     r_idx     <= w_idx_inc;
                     r_rd_addr <= r_a_base + ADDR_W'(w_idx_inc);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign acc_out     = r_acc_out;
   assign mem_rd_en   = r_rd_en;
   assign mem_rd_addr = r_rd_addr;
   assign mac_f1      = r_f1;
   assign mac_f2      = r_f2;
   assign mac_a1      = r_a1;

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Sequencer that drives the shared mac datapath (result = f1*f2 + a1) to compute an N-element dot product. Operands come from an on-chip operand memory. It sits between the AXI-lite register bank and the mac instance. The register bank supplies the command (start, length, base addresses). The block fetches operand pairs over a single synchronous read port, issues one MAC per element, accumulates through the a1 input, and reports the final sum with a done pulse.

Parameters:
DATA_W, 32, width of operands, accumulator and mac ports
ADDR_W, 10, operand memory word-address width
LEN_W, 10, width of element-count field
MAC_LAT, 2, cycles from mac inputs stable to mac_result valid (legal range 1..15)

Ports:
clock  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
start  in  1  command strobe, sampled only in IDLE
abort  in  1  cancel current command
len  in  LEN_W  element count, latched on accepted start
a_base  in  ADDR_W  word address of vector A element 0
b_base  in  ADDR_W  word address of vector B element 0
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse, acc_out updated in the same cycle
acc_out  out  DATA_W  last completed dot product
mem_rd_en  out  1  operand memory read enable
mem_rd_addr  out  ADDR_W  operand memory read address
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
mac_f1  out  DATA_W  mac multiplicand
mac_f2  out  DATA_W  mac multiplier
mac_a1  out  DATA_W  mac addend (running accumulator)
mac_result  in  DATA_W  mac output

Behaviour:
- Reset: state IDLE. busy=0, done=0, acc_out=0, mem_rd_en=0, mem_rd_addr=0, mac_f1/f2/a1=0, internal acc/idx/wait counter=0.
- All outputs are registered. mem_rd_addr and mac_* hold their last value when unused.
- States: IDLE, RD_A, RD_B, CAP_B, ISSUE, WB, DONE.
- IDLE:
  - start=1 and len!=0: latch len/a_base/b_base, acc=0, idx=0, go to RD_A.
  - start=1 and len==0: acc=0, go to DONE.
- RD_A: mem_rd_en=1, addr=a_base+idx. Go to RD_B.
- RD_B: mem_rd_en=1, addr=b_base+idx. Capture mem_rd_data as operand A. Go to CAP_B.
- CAP_B: mem_rd_en=0. Capture operand B. Go to ISSUE.
- ISSUE:
  - On entry: mac_f1=A, mac_f2=B, mac_a1=acc. Hold these stable for MAC_LAT cycles (wait counter).
  - Then go to WB.
- WB: acc<=mac_result.
  - If idx==len-1, go to DONE.
  - Otherwise idx<=idx+1 and go to RD_A.
- DONE: done=1 for one cycle, acc_out<=acc (same edge), busy deasserts next cycle. Go to IDLE.
- Timing:
  - Per element: 4+MAC_LAT cycles.
  - done is high in cycle 1+len*(4+MAC_LAT) after the start-sampling edge; len==0 gives 1.
- Address arithmetic is modulo 2^ADDR_W; base+idx wraps silently.
- Accumulation width is DATA_W and wraps. Overflow is the mac's concern; no saturation.
- start while busy: ignored and not queued.
- abort=1 in any non-IDLE state: go to IDLE next edge. busy=0 and mem_rd_en=0; no done pulse; acc_out unchanged.
- abort and start together in IDLE: start wins. abort wins in all other states.
- abort has priority over the DONE transition: abort in DONE still gives done=1 that cycle, because done is registered.
- Reset mid-operation: immediate return to reset values; acc_out cleared.
- Back-to-back: start sampled in the IDLE cycle right after DONE is accepted (zero-bubble restart not required).

Test Plan:
- Memory A[0..3]=1,2,3,4 at a_base=0, B[0..3]=5,6,7,8 at b_base=16, len=4, MAC_LAT=2 -> done exactly 25 cycles after start, acc_out=70, busy low the next cycle.
- len=0 -> done 1 cycle after start, acc_out=0, mem_rd_en never asserted.
- a_base=1022, len=4, ADDR_W=10 -> read addresses 1022,1023,0,1 observed on mem_rd_addr.
- Overflow: A=B=0x00010000, len=2 -> acc_out=0x00000000 (wrap).
- abort asserted in the ISSUE of element 2 of a len=4 command -> IDLE next cycle, no done, acc_out keeps the previous 70.
- start pulsed while busy, then reset asserted mid-command -> second start ignored; on reset all outputs are 0 asynchronously; a new command after reset completes normally.
